// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU core: datapath widths and the bit
// positions of the fields inside a 16-bit Hack instruction.
package hack_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  // Instruction field positions (C-instruction layout 1xx a cccccc ddd jjj)
  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

endpackage

// File: rtl/hack_cpu_alu.sv
// Hack ALU: purely combinational.
// Ports:
//   x_i, y_i     operands
//   zx_i..no_i   control bits (zero/negate x, zero/negate y, add-vs-and, negate out)
//   out_o        result
//   zr_o         result == 0
//   ng_o         result is negative (MSB set)
module hack_cpu_alu
  import hack_pkg::*;
(
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  logic [WIDTH-1:0] x0, x1, y0, y1, f_out;

  always_comb begin
    x0    = zx_i ? '0 : x_i;
    x1    = nx_i ? ~x0 : x0;
    y0    = zy_i ? '0 : y_i;
    y1    = ny_i ? ~y0 : y0;
    f_out = f_i ? (x1 + y1) : (x1 & y1);
    out_o = no_i ? ~f_out : f_out;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: decodes one instruction per valid cycle, holds A/D/PC and
// drives the ALU with X = D, Y = A or M.
// Ports:
//   CLK, RST_N   clock (rising edge), async active-low reset
//   INST         current instruction (ROM[PC])
//   INST_VALID   1 = retire INST this cycle, 0 = stall
//   IN_M         RAM[ADDRESS_M] read data (combinational)
//   OUT_M        ALU result / RAM write data
//   WRITE_M      RAM write enable (combinational, same cycle)
//   ADDRESS_M    data address, the pre-update A
//   PC           instruction address
module hack_cpu
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  INST,
  input  logic              INST_VALID,
  input  logic [WIDTH-1:0]  IN_M,
  output logic [WIDTH-1:0]  OUT_M,
  output logic              WRITE_M,
  output logic [ADDR_W-1:0] ADDRESS_M,
  output logic [ADDR_W-1:0] PC
);

  logic [WIDTH-1:0]  a_q, a_d, d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zr, alu_ng;
  logic              is_c, take, wr;

  hack_cpu_alu u_alu (
    .x_i  (d_q),
    .y_i  (INST[A_BIT] ? IN_M : a_q),
    .zx_i (INST[COMP_HI]),
    .nx_i (INST[COMP_HI-1]),
    .zy_i (INST[COMP_HI-2]),
    .ny_i (INST[COMP_HI-3]),
    .f_i  (INST[COMP_LO+1]),
    .no_i (INST[COMP_LO]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  always_comb begin
    is_c = INST[IS_C];
    take = (INST[J_LT] & alu_ng) | (INST[J_EQ] & alu_zr) | (INST[J_GT] & ~alu_ng & ~alu_zr);
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    wr   = 1'b0;
    if (INST_VALID) begin
      if (!is_c) begin
        a_d  = {1'b0, INST[ADDR_W-1:0]};
        pc_d = pc_q + 1'b1;
      end else begin
        if (INST[DEST_A]) a_d = alu_out;
        if (INST[DEST_D]) d_d = alu_out;
        wr   = INST[DEST_M];
        // Jump target is the A value from before this instruction's write.
        pc_d = take ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= RESET_PC;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign OUT_M     = alu_out;
  assign WRITE_M   = wr & RST_N;  // never write RAM while held in reset
  assign ADDRESS_M = a_q[ADDR_W-1:0];
  assign PC        = pc_q;

endmodule

// File: tb/tb_hack_cpu.sv
module tb_hack_cpu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] INST;
  logic        INST_VALID;
  logic [15:0] IN_M;
  logic [15:0] OUT_M;
  logic        WRITE_M;
  logic [14:0] ADDRESS_M;
  logic [14:0] PC;

  int checks = 0;
  int failures = 0;

  hack_cpu dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INST      (INST),
    .INST_VALID(INST_VALID),
    .IN_M      (IN_M),
    .OUT_M     (OUT_M),
    .WRITE_M   (WRITE_M),
    .ADDRESS_M (ADDRESS_M),
    .PC        (PC)
  );

  always #5 CLK = ~CLK;

  // Drive an instruction and let it retire on the next rising edge.
  task automatic step(input logic [15:0] inst, input logic vld);
    INST = inst;
    INST_VALID = vld;
    @(posedge CLK);
    #1;
  endtask

  // Present "D" (comp only, no dest/jump) to expose D on OUT_M, no edge.
  task automatic peek_d(input logic [15:0] exp, input string name);
    INST = 16'hE300;
    INST_VALID = 1'b1;
    #1;
    checks++;
    if (OUT_M !== exp) begin
      failures++;
      $display("FAIL %s: D via OUT_M got %h expected %h", name, OUT_M, exp);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; INST = 16'h0000; INST_VALID = 1'b0; IN_M = 16'h0000;
    #1;
    checks++;
    if (PC !== 15'h0 || ADDRESS_M !== 15'h0 || WRITE_M !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: PC=%h ADDR=%h WM=%b expected 0/0/0", PC, ADDRESS_M, WRITE_M);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    step(16'h0007, 1'b1);
    step(16'hEC10, 1'b1);
    step(16'h0003, 1'b1);
    checks++;
    if (PC !== 15'd3 || ADDRESS_M !== 15'd3) begin
      failures++;
      $display("FAIL reset_prerun: PC=%h ADDR=%h expected 3/3", PC, ADDRESS_M);
    end
    // Assert reset between edges with a writing instruction on the bus.
    INST = 16'hE7C8; INST_VALID = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (PC !== 15'h0 || ADDRESS_M !== 15'h0 || WRITE_M !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: PC=%h ADDR=%h WM=%b expected 0/0/0", PC, ADDRESS_M, WRITE_M);
    end
    peek_d(16'h0000, "reset_d");
    @(negedge CLK); RST_N = 1'b1;
    INST_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (PC !== 15'h0) begin
      failures++;
      $display("FAIL reset_restart: PC=%h expected 0", PC);
    end
  endtask

  task automatic test_a_then_d();
    INST = 16'h0005; INST_VALID = 1'b1; #1;
    checks++;
    if (WRITE_M !== 1'b0) begin
      failures++; $display("FAIL ainst_wm: WRITE_M=%b expected 0", WRITE_M);
    end
    step(16'h0005, 1'b1);
    INST = 16'hEC10; #1;
    checks++;
    if (WRITE_M !== 1'b0 || OUT_M !== 16'h0005) begin
      failures++; $display("FAIL dA_comb: WM=%b OUT=%h expected 0/0005", WRITE_M, OUT_M);
    end
    step(16'hEC10, 1'b1);
    checks++;
    if (ADDRESS_M !== 15'h5 || PC !== 15'd2) begin
      failures++; $display("FAIL dA_regs: A=%h PC=%h expected 5/2", ADDRESS_M, PC);
    end
    peek_d(16'h0005, "dA_d");
  endtask

  task automatic test_write_m();
    step(16'h0010, 1'b1);           // PC=3
    INST = 16'hE7C8; INST_VALID = 1'b1; #1;
    checks++;
    if (OUT_M !== 16'h0006 || WRITE_M !== 1'b1 || ADDRESS_M !== 15'h10) begin
      failures++;
      $display("FAIL write_m: OUT=%h WM=%b ADDR=%h expected 0006/1/0010", OUT_M, WRITE_M, ADDRESS_M);
    end
    step(16'hE7C8, 1'b1);
    checks++;
    if (PC !== 15'd4) begin
      failures++; $display("FAIL write_m_pc: PC=%h expected 4", PC);
    end
  endtask

  task automatic test_jumps();
    step(16'h0100, 1'b1);           // A=0x100, PC=5
    step(16'hE301, 1'b1);           // D=5 > 0 -> taken
    checks++;
    if (PC !== 15'h0100) begin
      failures++; $display("FAIL jgt: PC=%h expected 0100", PC);
    end
    step(16'hE302, 1'b1);           // D != 0 -> not taken
    checks++;
    if (PC !== 15'h0101) begin
      failures++; $display("FAIL jeq: PC=%h expected 0101", PC);
    end
    step(16'hEA87, 1'b1);           // unconditional
    checks++;
    if (PC !== 15'h0100) begin
      failures++; $display("FAIL jmp: PC=%h expected 0100", PC);
    end
  endtask

  task automatic test_am();
    step(16'h0020, 1'b1);           // PC=0x101
    IN_M = 16'h0001;
    INST = 16'hFCA8; INST_VALID = 1'b1; #1;
    checks++;
    if (OUT_M !== 16'h0000 || WRITE_M !== 1'b1 || ADDRESS_M !== 15'h20) begin
      failures++;
      $display("FAIL am_comb: OUT=%h WM=%b ADDR=%h expected 0000/1/0020", OUT_M, WRITE_M, ADDRESS_M);
    end
    step(16'hFCA8, 1'b1);
    checks++;
    if (ADDRESS_M !== 15'h0 || PC !== 15'h0102) begin
      failures++; $display("FAIL am_regs: A=%h PC=%h expected 0000/0102", ADDRESS_M, PC);
    end
    // A=0;JMP with old A=0x30: target must be the pre-update A.
    step(16'h0030, 1'b1);
    step(16'hEAA7, 1'b1);
    checks++;
    if (PC !== 15'h0030 || ADDRESS_M !== 15'h0) begin
      failures++; $display("FAIL destA_jmp: PC=%h A=%h expected 0030/0000", PC, ADDRESS_M);
    end
    peek_d(16'h0005, "am_d");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      INST = 16'hE7C8; INST_VALID = 1'b0; #1;
      checks++;
      if (WRITE_M !== 1'b0) begin
        failures++; $display("FAIL stall_wm%0d: WRITE_M=%b expected 0", i, WRITE_M);
      end
      step(16'hE7C8, 1'b0);
      checks++;
      if (PC !== 15'h0030 || ADDRESS_M !== 15'h0) begin
        failures++; $display("FAIL stall_regs%0d: PC=%h A=%h expected 0030/0000", i, PC, ADDRESS_M);
      end
    end
    peek_d(16'h0005, "stall_d");
  endtask

  task automatic test_wrap();
    step(16'h7FFF, 1'b1);
    step(16'hEA87, 1'b1);
    checks++;
    if (PC !== 15'h7FFF) begin
      failures++; $display("FAIL wrap_setup: PC=%h expected 7fff", PC);
    end
    step(16'h0001, 1'b1);
    checks++;
    if (PC !== 15'h0000 || ADDRESS_M !== 15'h1) begin
      failures++; $display("FAIL wrap: PC=%h A=%h expected 0000/0001", PC, ADDRESS_M);
    end
  endtask

  initial begin
    test_reset();
    test_a_then_d();
    test_write_m();
    test_jumps();
    test_am();
    test_stall();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
